// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  // FETCH: request outstanding; HOLD: stalled instruction parked, no request;
  // DRAIN: waiting out a request whose response will be thrown away
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INST_NOP = 32'b0;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Instruction addresses are word aligned; low two bits of a target are dropped
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry buffer parking a fetched instruction during a stall
import fetch_pkg::*;

module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pcn,
  output logic [31:0] hold_inst,
  output logic [31:0] hold_pcn
);

  // Capture on load; clearing afterwards keeps stale words out of debug views
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_inst <= INST_NOP;
      hold_pcn  <= 32'b0;
    end else if (load) begin
      hold_inst <= load_inst;
      hold_pcn  <= load_pcn;
    end else if (clear) begin
      hold_inst <= INST_NOP;
      hold_pcn  <= 32'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, imem request/ack handshake and IF/ID presentation
import fetch_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc_next,
  output logic        inst_valid
);

  fetch_state_t st;
  logic [31:0]  pc;
  logic [31:0]  tgt;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_tgt;
  logic [31:0]  hold_inst;
  logic [31:0]  hold_pcn;
  logic         fetch_hit;
  logic         buf_load;
  logic         buf_clear;

  assign pc_plus4     = pc + PC_STEP;
  assign redirect_tgt = align_pc(redirect_pc);

  // A response is usable only if no redirect kills it in the same cycle
  assign fetch_hit = (st == FETCH) && imem_ack && !redirect;
  assign buf_load  = fetch_hit && stall;
  assign buf_clear = (st == HOLD) && (redirect || !stall);

  fetch_hold_buf u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_inst (imem_rdata),
    .load_pcn  (pc_plus4),
    .hold_inst (hold_inst),
    .hold_pcn  (hold_pcn)
  );

  // PC and fetch state; a redirect against an unacked request is deferred via tgt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= FETCH;
      pc  <= RESET_PC;
      tgt <= 32'b0;
    end else begin
      case (st)
        FETCH: begin
          if (redirect) begin
            if (imem_ack) begin
              pc <= redirect_tgt;
            end else begin
              tgt <= redirect_tgt;
              st  <= DRAIN;
            end
          end else if (imem_ack) begin
            pc <= pc_plus4;
            if (stall) st <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc <= redirect_tgt;
            st <= FETCH;
          end else if (!stall) begin
            st <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc <= redirect ? redirect_tgt : tgt;
            st <= FETCH;
          end else if (redirect) begin
            tgt <= redirect_tgt;
          end
        end
        default: st <= FETCH;
      endcase
    end
  end

  // Memory side: address always tracks pc so it stays stable through a wait
  assign imem_addr = pc;

  // Output decode; reset forces the request off immediately
  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    inst       = INST_NOP;
    pc_next    = 32'b0;
    if (!rst) begin
      case (st)
        FETCH: begin
          imem_req = 1'b1;
          if (fetch_hit) begin
            inst_valid = 1'b1;
            inst       = imem_rdata;
            pc_next    = pc_plus4;
          end
        end
        HOLD: begin
          inst_valid = 1'b1;
          inst       = hold_inst;
          pc_next    = hold_pcn;
        end
        DRAIN: imem_req = 1'b1;
        default: imem_req = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc_next;
  logic        inst_valid;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference: address of the request in flight, a parked instruction, a doomed request
  logic [31:0] m_addr;
  logic        m_held;
  logic [31:0] m_hinst;
  logic [31:0] m_hpcn;
  logic        m_stale;
  logic [31:0] m_after;
  logic [31:0] m_flow;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .pc_next     (pc_next),
    .inst_valid  (inst_valid)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = word_of(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rpc, input logic a);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    imem_ack    = a;
    #1;
  endtask

  // Compare every output against the reference and the program-order flow
  task automatic check_outputs();
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pcn;
    e_valid = m_held ? 1'b1 : (imem_ack && !redirect && !m_stale);
    e_inst  = m_held ? m_hinst : (e_valid ? word_of(m_addr) : 32'b0);
    e_pcn   = m_held ? m_hpcn  : (e_valid ? m_addr + 32'd4 : 32'b0);
    chk("req", {31'b0, imem_req}, {31'b0, !m_held});
    if (!m_held) chk("addr", imem_addr, m_addr);
    chk("valid", {31'b0, inst_valid}, {31'b0, e_valid});
    chk("inst", inst, e_inst);
    chk("pc_next", pc_next, e_pcn);
    if (e_valid && !stall && !redirect) begin
      chk("flow_pcn", pc_next, m_flow + 32'd4);
      chk("flow_inst", inst, word_of(m_flow));
    end
  endtask

  task automatic tick();
    logic [31:0] tgt;
    tgt = redirect_pc & ~32'h3;
    @(posedge clk);
    if (redirect) m_flow = tgt;
    else if ((m_held || (imem_ack && !m_stale)) && !stall) m_flow = m_flow + 32'd4;
    if (m_held) begin
      if (redirect) begin
        m_held = 1'b0;
        m_addr = tgt;
      end else if (!stall) begin
        m_held = 1'b0;
      end
    end else if (m_stale) begin
      if (imem_ack) begin
        m_addr  = redirect ? tgt : m_after;
        m_stale = 1'b0;
      end else if (redirect) begin
        m_after = tgt;
      end
    end else if (redirect) begin
      if (imem_ack) m_addr = tgt;
      else begin
        m_stale = 1'b1;
        m_after = tgt;
      end
    end else if (imem_ack) begin
      if (stall) begin
        m_held  = 1'b1;
        m_hinst = word_of(m_addr);
        m_hpcn  = m_addr + 32'd4;
      end
      m_addr = m_addr + 32'd4;
    end
    #1;
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rpc, input logic a);
    drive(s, r, rpc, a);
    check_outputs();
    tick();
  endtask

  task automatic apply_reset();
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'b0; imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pcn", pc_next, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_addr = RST_PC; m_held = 1'b0; m_hinst = 32'b0; m_hpcn = 32'b0;
    m_stale = 1'b0; m_after = 32'b0; m_flow = RST_PC;
  endtask

  initial begin
    apply_reset();

    // zero-wait memory: one instruction per cycle
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'b0, 1'b1);
      check_outputs();
      chk("zw_addr", imem_addr, RST_PC + 32'(4 * i));
      chk("zw_pcn", pc_next, RST_PC + 32'(4 * i + 4));
      chk("zw_valid", {31'b0, inst_valid}, 32'd1);
      tick();
    end

    // 3-cycle latency
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 32'b0, 1'b0);
      drive(1'b0, 1'b0, 32'b0, 1'b0);
      check_outputs();
      chk("lat_wait_addr", imem_addr, 32'h10C + 32'(4 * k));
      tick();
      drive(1'b0, 1'b0, 32'b0, 1'b1);
      check_outputs();
      chk("lat_addr", imem_addr, 32'h10C + 32'(4 * k));
      chk("lat_valid", {31'b0, inst_valid}, 32'd1);
      tick();
    end

    // stall at 0x200 parks the instruction
    step(1'b0, 1'b1, 32'h200, 1'b1);
    step(1'b1, 1'b0, 32'b0, 1'b1);
    drive(1'b1, 1'b0, 32'b0, 1'b0);
    check_outputs();
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_pcn", pc_next, 32'h204);
    chk("hold_inst", inst, word_of(32'h200));
    tick();
    step(1'b0, 1'b0, 32'b0, 1'b0);
    drive(1'b0, 1'b0, 32'b0, 1'b0);
    check_outputs();
    chk("release_addr", imem_addr, 32'h204);
    chk("release_req", {31'b0, imem_req}, 32'd1);
    tick();

    // redirect while 0x300 is pending
    step(1'b0, 1'b1, 32'h300, 1'b1);
    step(1'b0, 1'b1, 32'h400, 1'b0);
    drive(1'b0, 1'b0, 32'b0, 1'b0);
    check_outputs();
    chk("drain_addr", imem_addr, 32'h300);
    tick();
    drive(1'b0, 1'b0, 32'b0, 1'b1);
    check_outputs();
    chk("drain_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'b0, 1'b0);
    check_outputs();
    chk("drain_next", imem_addr, 32'h400);
    tick();

    // redirect to unaligned target while stalled in HOLD
    step(1'b1, 1'b0, 32'b0, 1'b1);
    step(1'b1, 1'b1, 32'h403, 1'b0);
    drive(1'b0, 1'b0, 32'b0, 1'b0);
    check_outputs();
    chk("hredir_valid", {31'b0, inst_valid}, 32'd0);
    chk("hredir_addr", imem_addr, 32'h400);
    tick();

    // pc wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    drive(1'b0, 1'b0, 32'b0, 1'b1);
    check_outputs();
    chk("wrap_pcn", pc_next, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'b0, 1'b0);
    check_outputs();
    chk("wrap_addr", imem_addr, 32'h0);
    tick();

    // reset mid-wait drops the request and restarts at RESET_PC
    apply_reset();
    drive(1'b0, 1'b0, 32'b0, 1'b0);
    check_outputs();
    chk("restart_addr", imem_addr, RST_PC);
    tick();

    // randomized traffic against the reference
    for (int n = 0; n < 800; n++) begin
      logic [31:0] rpc;
      if (n == 400) apply_reset();
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 32'h0000_FFFF));
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, rpc, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the pipelined MIPS core: owns the program counter, drives a variable-latency instruction-memory request/acknowledge interface, and presents instruction plus PC+4 to the IF/ID pipeline register. It absorbs hazard stalls with a one-entry hold buffer and applies branch/jump redirects from ID without losing or duplicating instructions. Its `inst`/`pc_next`/`inst_valid` outputs feed IF/ID `Inst`, `pcNext` and the IF/ID write enable directly.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hazard unit: IF/ID will not write this cycle
- redirect  in  1  taken branch/jump resolved in ID
- redirect_pc  in  32  target address, bits [1:0] ignored (forced 00)
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  32  fetch address, stable while imem_req high
- imem_ack  in  1  imem_rdata valid this cycle; may coincide with first request cycle
- imem_rdata  in  32  instruction word
- inst  out  32  instruction to IF/ID; 32'b0 when inst_valid=0
- pc_next  out  32  fetched address + 4; 32'b0 when inst_valid=0
- inst_valid  out  1  inst/pc_next valid for IF/ID capture

## Operation
- State: pc (32), tgt (32), hold_inst (32), hold_pcn (32), st in {FETCH, HOLD, DRAIN}.
- FETCH: imem_req=1, imem_addr=pc. inst_valid = imem_ack & ~redirect; inst=imem_rdata, pc_next=pc+4.
  - ack & ~redirect & ~stall: pc<=pc+4, stay FETCH.
  - ack & ~redirect & stall: hold_inst<=imem_rdata, hold_pcn<=pc+4, pc<=pc+4, go HOLD.
  - redirect & ack: response discarded, pc<=redirect_pc, stay FETCH.
  - redirect & ~ack: tgt<=redirect_pc, go DRAIN (address must stay stable).
  - ~ack & ~redirect: hold everything (stall irrelevant).
- HOLD: imem_req=0, inst_valid=1, outputs from hold buffer.
  - redirect: buffer discarded, pc<=redirect_pc, go FETCH.
  - ~stall: buffer consumed, go FETCH.
  - stall: stay.
- DRAIN: imem_req=1, imem_addr=pc (old), inst_valid=0.
  - ack: pc<=tgt (or redirect_pc if redirect same cycle), go FETCH.
  - redirect & ~ack: tgt<=redirect_pc, stay.
- Priority: rst > redirect > stall.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); redirect_pc[1:0] forced 00.

## Timing
- Reset: st=FETCH, pc=RESET_PC, tgt/hold regs 0; imem_req forced 0 while rst high; inst_valid=0, inst=0, pc_next=0.
- First imem_req in first cycle after rst deasserts.
- Zero-wait memory (ack in request cycle): 1 instruction/cycle, combinational imem_rdata -> inst.
- N-cycle memory: inst_valid in the ack cycle only; next request the following cycle.
- Redirect penalty: target fetch requested the cycle after redirect (FETCH/HOLD) or the cycle after the stale ack (DRAIN).
- Stall with instruction in HOLD: inst/pc_next constant every stalled cycle; no new request issued.
- rst mid-request: request dropped immediately; memory must tolerate abandoned request.

## Structure
- fetch_pkg: state enum (FETCH, HOLD, DRAIN), INST_NOP = 32'b0, PC_STEP = 32'd4.
- One sub-module natural: fetch_hold_buf (one-entry inst/pc_next buffer with load/clear).
- PC register and FSM in fetch_unit top.

## Test plan
- Reset RESET_PC=32'h0000_0100, zero-wait memory -> imem_addr 0x100,0x104,0x108 on consecutive cycles, pc_next 0x104,0x108,0x10C, inst_valid=1 each cycle.
- 3-cycle memory latency -> inst_valid one cycle per 3, imem_addr stable across wait, no gaps or duplicates.
- Ack at addr 0x200 with stall high 2 cycles -> HOLD, inst/pc_next=0x204 held, imem_req=0, released -> next request 0x204.
- redirect to 0x400 while request at 0x300 still pending -> imem_addr stays 0x300 until ack, 0x300 word not presented, next request 0x400.
- redirect to 0x403 with stall high in HOLD -> buffer dropped, inst_valid=0 next cycle, request at 0x400.
- pc=32'hFFFF_FFFC fetched -> pc_next=0, next imem_addr=0; rst asserted mid-wait -> imem_req=0 same cycle, fetch restarts at RESET_PC.
